// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with global stall and per-stage flush (bubble insertion).
// Optional killed-instruction counter enabled by defining PIPE_FLUSH_COUNT_EN.
module pipe_stage_chain #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned STAGES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [CTRL_W-1:0] Ctrl_in,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              Valid_in,
    input  logic              Stall,
    input  logic [STAGES-1:0] Flush,
    output logic [CTRL_W-1:0] Ctrl_out,
    output logic [DATA_W-1:0] Data_out,
    output logic              Valid_out,
    output logic              Busy
`ifdef PIPE_FLUSH_COUNT_EN
    ,
    input  logic              Count_Clr,
    output logic [15:0]       Flush_Count
`endif
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [CTRL_W-1:0] ctrl_d [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];

    // Entry each stage would load when neither stalled nor flushed
    logic [STAGES-1:0] src_valid;
    logic [CTRL_W-1:0] src_ctrl [STAGES];
    logic [DATA_W-1:0] src_data [STAGES];

    always_comb begin
        src_valid[0] = Valid_in;
        src_ctrl[0]  = Ctrl_in;
        src_data[0]  = Data_in;
        for (int i = 1; i < int'(STAGES); i++) begin
            src_valid[i] = valid_q[i-1];
            src_ctrl[i]  = ctrl_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < int'(STAGES); i++) begin
            valid_d[i] = valid_q[i];
            ctrl_d[i]  = ctrl_q[i];
            data_d[i]  = data_q[i];
            if (Flush[i]) begin
                valid_d[i] = 1'b0;
                ctrl_d[i]  = '0;
            end else if (!Stall) begin
                valid_d[i] = src_valid[i];
                ctrl_d[i]  = src_valid[i] ? src_ctrl[i] : '0;
                data_d[i]  = src_data[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                ctrl_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(STAGES); i++) begin
                ctrl_q[i] <= ctrl_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign Valid_out = valid_q[STAGES-1];
    assign Ctrl_out  = ctrl_q[STAGES-1];
    assign Data_out  = data_q[STAGES-1];
    assign Busy      = |valid_q;

`ifdef PIPE_FLUSH_COUNT_EN
    logic [15:0] count_q, count_d;
    logic        kill_hit;

    // Under stall the entry a flush kills is the one already held in the stage
    always_comb begin
        kill_hit = |(Flush & (Stall ? valid_q : src_valid));
        count_d  = count_q;
        if (Count_Clr) begin
            count_d = '0;
        end else if (kill_hit && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Flush_Count = count_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (STAGES=2): random traffic against a per-stage reference
// model, plus directed reset/latency/stall/flush/bubble cases and the optional flush counter.
module tb_pipe_stage_chain;

    localparam int S  = 2;
    localparam int CW = 16;
    localparam int DW = 128;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [CW-1:0] Ctrl_in;
    logic [DW-1:0] Data_in;
    logic          Valid_in;
    logic          Stall;
    logic [S-1:0]  Flush;
    logic [CW-1:0] Ctrl_out;
    logic [DW-1:0] Data_out;
    logic          Valid_out;
    logic          Busy;
    logic          clr;
`ifdef PIPE_FLUSH_COUNT_EN
    logic [15:0]   Flush_Count;
`endif

    pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .STAGES(S)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Ctrl_in    (Ctrl_in),
        .Data_in    (Data_in),
        .Valid_in   (Valid_in),
        .Stall      (Stall),
        .Flush      (Flush),
        .Ctrl_out   (Ctrl_out),
        .Data_out   (Data_out),
        .Valid_out  (Valid_out),
        .Busy       (Busy)
`ifdef PIPE_FLUSH_COUNT_EN
        ,
        .Count_Clr  (clr),
        .Flush_Count(Flush_Count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          busy;
        logic [15:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference: each slot holds the entry currently sitting at that depth of the chain
    logic          mv [S];
    logic [CW-1:0] mc [S];
    logic [DW-1:0] md [S];
    int            mcnt;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            mc[i] = '0;
            md[i] = '0;
        end
        mcnt = 0;
    endtask

    task automatic model_edge();
        logic          nv [S];
        logic [CW-1:0] nc [S];
        logic [DW-1:0] nd [S];
        logic          inc_v;
        logic          hit;
        hit = 1'b0;
        for (int i = 0; i < S; i++) begin
            inc_v = (i == 0) ? Valid_in : mv[i-1];
            if (Stall) inc_v = mv[i];
            if (Flush[i] && inc_v) hit = 1'b1;
            if (Flush[i]) begin
                nv[i] = 1'b0; nc[i] = '0; nd[i] = md[i];
            end else if (Stall) begin
                nv[i] = mv[i]; nc[i] = mc[i]; nd[i] = md[i];
            end else if (i == 0) begin
                nv[i] = Valid_in; nc[i] = Valid_in ? Ctrl_in : '0; nd[i] = Data_in;
            end else begin
                nv[i] = mv[i-1]; nc[i] = mc[i-1]; nd[i] = md[i-1];
            end
        end
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i]; mc[i] = nc[i]; md[i] = nd[i];
        end
        if (clr) mcnt = 0;
        else if (hit && mcnt < 65535) mcnt++;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.v    = mv[S-1];
        e.c    = mc[S-1];
        e.d    = md[S-1];
        e.busy = 1'b0;
        for (int i = 0; i < S; i++) e.busy |= mv[i];
        e.cnt  = 16'(mcnt);
        return e;
    endfunction

    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic st, input logic [S-1:0] fl, input logic cl);
        Valid_in = v; Ctrl_in = c; Data_in = d; Stall = st; Flush = fl; clr = cl;
        @(posedge Clk);
        model_edge();
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: one expected output tuple per clock edge, compared mid-cycle
    always @(negedge Clk) begin
        if (Reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_valid", DW'(Valid_out), DW'(e.v));
            chk("sb_ctrl", DW'(Ctrl_out), DW'(e.c));
            chk("sb_data", Data_out, e.d);
            chk("sb_busy", DW'(Busy), DW'(e.busy));
            chk("sb_invariant", DW'(!Valid_out && Ctrl_out != '0), '0);
`ifdef PIPE_FLUSH_COUNT_EN
            chk("sb_count", DW'(Flush_Count), DW'(e.cnt));
`endif
        end
    end

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        Reset = 1'b0; Valid_in = 0; Ctrl_in = '0; Data_in = '0; Stall = 0; Flush = '0; clr = 0;
        model_reset();
        #12;
        chk("rst_valid", DW'(Valid_out), '0);
        chk("rst_busy", DW'(Busy), '0);
        chk("rst_data", Data_out, '0);
        @(negedge Clk) Reset = 1'b1;

        // T2: latency 2, single-cycle entry
        step(1'b1, 16'h00A5, 128'h1234, 1'b0, '0, 1'b0);
        chk("t2_not_early", DW'(Valid_out), '0);
        idle();
        chk("t2_valid", DW'(Valid_out), 1);
        chk("t2_ctrl", DW'(Ctrl_out), 128'h00A5);
        chk("t2_data", Data_out, 128'h1234);
        idle();
        chk("t2_gone", DW'(Valid_out), '0);
        idle();

        // T3: 3 stall cycles push arrival from cycle 2 to cycle 5
        step(1'b1, 16'h0033, 128'h5555, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'h0077, 128'h9999, 1'b1, '0, 1'b0);
            chk("t3_held", DW'(Valid_out), '0);
        end
        idle();
        chk("t3_arrive", DW'(Valid_out), 1);
        chk("t3_ctrl", DW'(Ctrl_out), 128'h0033);
        idle();

        // T4: stall + flush stage 0 with both stages valid
        step(1'b1, 16'h0101, 128'hAAAA, 1'b0, '0, 1'b0);
        step(1'b1, 16'h0202, 128'hBBBB, 1'b0, '0, 1'b0);
        step(1'b1, 16'h0303, 128'hCCCC, 1'b1, 2'b01, 1'b0);
        chk("t4_out_held", DW'(Valid_out), 1);
        chk("t4_ctrl_held", DW'(Ctrl_out), 128'h0101);
        idle();
        chk("t4_bubble_v", DW'(Valid_out), '0);
        chk("t4_bubble_c", DW'(Ctrl_out), '0);
        chk("t4_bubble_d", Data_out, 128'hBBBB);
        idle();

        // T5: invalid entry has ctrl forced to zero, data kept
        step(1'b0, 16'hFFFF, 128'hBEEF, 1'b0, '0, 1'b0);
        step(1'b0, 16'hFFFF, 128'h0001, 1'b0, '0, 1'b0);
        chk("t5_valid", DW'(Valid_out), '0);
        chk("t5_ctrl", DW'(Ctrl_out), '0);
        chk("t5_data", Data_out, 128'hBEEF);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), rnd_data(),
                 1'($urandom_range(0, 3) == 0),
                 {1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0)},
                 1'($urandom_range(0, 63) == 0));
        end

        // T1: async reset mid-traffic, mid-stall
        step(1'b1, 16'h1111, 128'h2222, 1'b0, '0, 1'b0);
        step(1'b1, 16'h3333, 128'h4444, 1'b1, '0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk("t1_valid", DW'(Valid_out), '0);
        chk("t1_ctrl", DW'(Ctrl_out), '0);
        chk("t1_data", Data_out, '0);
        chk("t1_busy", DW'(Busy), '0);
        exp_q.delete();
        model_reset();
        @(negedge Clk) Reset = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), rnd_data(),
                 1'($urandom_range(0, 4) == 0), S'($urandom_range(0, 3)), 1'b0);
        end

`ifdef PIPE_FLUSH_COUNT_EN
        // T6: saturation then clear-over-increment
        for (int k = 0; k < 70000; k++) step(1'b1, 16'h0001, '0, 1'b0, 2'b01, 1'b0);
        chk("t6_sat", DW'(Flush_Count), 128'hFFFF);
        step(1'b1, 16'h0001, '0, 1'b0, 2'b01, 1'b1);
        chk("t6_clr", DW'(Flush_Count), '0);
        step(1'b1, 16'h0001, '0, 1'b0, 2'b01, 1'b0);
        chk("t6_restart", DW'(Flush_Count), 128'h1);
`endif
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
